// File: rtl/qproc_mem_loader.sv
// PS-side memory sequencer: packs 32-bit stream words into program/data/wave
// memory entries on write jobs and unpacks read entries onto a 32-bit stream.
module qproc_mem_loader #(
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 16
) (
  input  logic             ps_clk_i,
  input  logic             ps_rst_ni,
  input  logic             cfg_start_i,
  input  logic             cfg_dir_i,
  input  logic [1:0]       cfg_sel_i,
  input  logic [15:0]      cfg_addr_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [31:0]      s_dt_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [31:0]      m_dt_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       ps_mem_sel_o,
  output logic             ps_mem_we_o,
  output logic [15:0]      ps_mem_addr_o,
  output logic [167:0]     ps_mem_w_dt_o,
  input  logic [167:0]     ps_mem_r_dt_i
);

  localparam int MEM_W = 168;
  localparam int BUF_W = 192;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_FILL   = 3'd1,
    ST_WR_COMMIT = 3'd2,
    ST_RD_ISSUE  = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_RD_DRAIN  = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  function automatic logic [2:0] last_word(input logic [1:0] sel);
    logic [2:0] idx;
    case (sel)
      2'd1:    idx = 3'd2;
      2'd2:    idx = 3'd0;
      2'd3:    idx = 3'd5;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [MEM_W-1:0] width_mask(input logic [1:0] sel);
    logic [MEM_W-1:0] m;
    case (sel)
      2'd1:    m = {96'd0, {72{1'b1}}};
      2'd2:    m = {136'd0, {32{1'b1}}};
      2'd3:    m = {MEM_W{1'b1}};
      default: m = {MEM_W{1'b0}};
    endcase
    return m;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [15:0]      r_addr, w_addr_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [2:0]       r_k, w_k_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic [BUF_W-1:0] r_pack, w_pack_nxt;
  logic [BUF_W-1:0] r_unpack, w_unpack_nxt;
  logic             r_err, w_err_nxt;

  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_s_ready, w_s_ready_nxt;
  logic             r_m_valid, w_m_valid_nxt;
  logic             r_we, w_we_nxt;
  logic [1:0]       r_mem_sel, w_mem_sel_nxt;
  logic [MEM_W-1:0] r_w_dt, w_w_dt_nxt;
  logic [31:0]      r_m_dt, w_m_dt_nxt;

  logic [2:0]       w_last_k;
  logic             w_last_entry;

  assign w_last_k     = last_word(r_sel);
  assign w_last_entry = (r_rem == LEN_W'(1'b1));

  // Sequencer next state and datapath; abort overrides every other event.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_addr_nxt   = r_addr;
    w_rem_nxt    = r_rem;
    w_k_nxt      = r_k;
    w_lat_nxt    = r_lat;
    w_pack_nxt   = r_pack;
    w_unpack_nxt = r_unpack;
    w_err_nxt    = r_err;
    if (abort_i && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_k_nxt     = 3'd0;
      w_pack_nxt  = {BUF_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start_i) begin
            if ((cfg_sel_i == 2'd0) || (cfg_len_i == {LEN_W{1'b0}})) begin
              w_err_nxt = 1'b1;
            end else begin
              w_err_nxt   = 1'b0;
              w_sel_nxt   = cfg_sel_i;
              w_addr_nxt  = cfg_addr_i;
              w_rem_nxt   = cfg_len_i;
              w_k_nxt     = 3'd0;
              w_lat_nxt   = {LAT_W{1'b0}};
              w_pack_nxt  = {BUF_W{1'b0}};
              w_state_nxt = cfg_dir_i ? ST_RD_ISSUE : ST_WR_FILL;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WR_FILL: begin
          if (s_valid_i) begin
            w_pack_nxt[{r_k, 5'd0} +: 32] = s_dt_i;
            if (r_k == w_last_k) begin
              w_state_nxt = ST_WR_COMMIT;
            end else begin
              w_k_nxt = r_k + 3'd1;
            end
          end else begin
            w_state_nxt = ST_WR_FILL;
          end
        end
        ST_WR_COMMIT: begin
          w_addr_nxt  = r_addr + 16'd1;
          w_rem_nxt   = r_rem - LEN_W'(1'b1);
          w_k_nxt     = 3'd0;
          w_pack_nxt  = {BUF_W{1'b0}};
          w_state_nxt = w_last_entry ? ST_DONE : ST_WR_FILL;
        end
        ST_RD_ISSUE: begin
          w_lat_nxt   = {LAT_W{1'b0}};
          w_state_nxt = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_lat == LAT_W'(RD_LAT - 1)) begin
            w_unpack_nxt = {{(BUF_W-MEM_W){1'b0}}, ps_mem_r_dt_i & width_mask(r_sel)};
            w_k_nxt      = 3'd0;
            w_state_nxt  = ST_RD_DRAIN;
          end else begin
            w_lat_nxt = r_lat + LAT_W'(1'b1);
          end
        end
        ST_RD_DRAIN: begin
          if (m_ready_i) begin
            if (r_k == w_last_k) begin
              w_addr_nxt  = r_addr + 16'd1;
              w_rem_nxt   = r_rem - LEN_W'(1'b1);
              w_k_nxt     = 3'd0;
              w_state_nxt = w_last_entry ? ST_DONE : ST_RD_ISSUE;
            end else begin
              w_k_nxt = r_k + 3'd1;
            end
          end else begin
            w_state_nxt = ST_RD_DRAIN;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state only.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_done_nxt    = (w_state_nxt == ST_DONE);
    w_s_ready_nxt = (w_state_nxt == ST_WR_FILL);
    w_m_valid_nxt = (w_state_nxt == ST_RD_DRAIN);
    w_we_nxt      = (w_state_nxt == ST_WR_COMMIT);
    w_mem_sel_nxt = 2'd0;
    w_w_dt_nxt    = {MEM_W{1'b0}};
    w_m_dt_nxt    = 32'd0;
    if (w_busy_nxt) begin
      w_mem_sel_nxt = w_sel_nxt;
    end else begin
      w_mem_sel_nxt = 2'd0;
    end
    if (w_we_nxt) begin
      w_w_dt_nxt = w_pack_nxt[MEM_W-1:0] & width_mask(w_sel_nxt);
    end else begin
      w_w_dt_nxt = {MEM_W{1'b0}};
    end
    if (w_m_valid_nxt) begin
      w_m_dt_nxt = w_unpack_nxt[{w_k_nxt, 5'd0} +: 32];
    end else begin
      w_m_dt_nxt = 32'd0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge ps_clk_i or negedge ps_rst_ni) begin
    if (!ps_rst_ni) begin
      r_state   <= ST_IDLE;
      r_sel     <= 2'd0;
      r_addr    <= 16'd0;
      r_rem     <= {LEN_W{1'b0}};
      r_k       <= 3'd0;
      r_lat     <= {LAT_W{1'b0}};
      r_pack    <= {BUF_W{1'b0}};
      r_unpack  <= {BUF_W{1'b0}};
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_we      <= 1'b0;
      r_mem_sel <= 2'd0;
      r_w_dt    <= {MEM_W{1'b0}};
      r_m_dt    <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_addr    <= w_addr_nxt;
      r_rem     <= w_rem_nxt;
      r_k       <= w_k_nxt;
      r_lat     <= w_lat_nxt;
      r_pack    <= w_pack_nxt;
      r_unpack  <= w_unpack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_we      <= w_we_nxt;
      r_mem_sel <= w_mem_sel_nxt;
      r_w_dt    <= w_w_dt_nxt;
      r_m_dt    <= w_m_dt_nxt;
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign s_ready_o     = r_s_ready;
  assign m_valid_o     = r_m_valid;
  assign m_dt_o        = r_m_dt;
  assign ps_mem_sel_o  = r_mem_sel;
  assign ps_mem_we_o   = r_we;
  assign ps_mem_addr_o = r_addr;
  assign ps_mem_w_dt_o = r_w_dt;

endmodule

// File: tb/tb_qproc_mem_loader.sv
// Scoreboard bench for qproc_mem_loader: stimulus pushes expected strobes and
// read words into queues, a negedge monitor pops and compares them.
module tb_qproc_mem_loader;
  localparam int RD_LAT = 2;
  localparam int LEN_W  = 16;

  logic             clk, rst_n;
  logic             cfg_start, cfg_dir;
  logic [1:0]       cfg_sel;
  logic [15:0]      cfg_addr;
  logic [LEN_W-1:0] cfg_len;
  logic             abort;
  logic             busy_o, done_o, err_o;
  logic [31:0]      s_dt;
  logic             s_valid, s_ready_o;
  logic [31:0]      m_dt_o;
  logic             m_valid_o, m_ready;
  logic [1:0]       mem_sel_o;
  logic             mem_we_o;
  logic [15:0]      mem_addr_o;
  logic [167:0]     mem_w_dt_o, mem_r_dt;

  qproc_mem_loader #(.RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
    .ps_clk_i(clk), .ps_rst_ni(rst_n),
    .cfg_start_i(cfg_start), .cfg_dir_i(cfg_dir), .cfg_sel_i(cfg_sel),
    .cfg_addr_i(cfg_addr), .cfg_len_i(cfg_len), .abort_i(abort),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_dt_i(s_dt), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
    .m_dt_o(m_dt_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready),
    .ps_mem_sel_o(mem_sel_o), .ps_mem_we_o(mem_we_o), .ps_mem_addr_o(mem_addr_o),
    .ps_mem_w_dt_o(mem_w_dt_o), .ps_mem_r_dt_i(mem_r_dt)
  );

  typedef struct {
    logic [15:0]  addr;
    logic [1:0]   sel;
    logic [167:0] data;
  } wr_t;

  wr_t          exp_wr[$];
  logic [31:0]  exp_rd[$];
  logic [31:0]  stim_words[$];
  int           we_cyc[$];
  int           n_checks, n_fail;
  int           cyc, done_cnt, exp_done, last_evt_cyc, last_done_cyc, start_cyc;
  int           rdy_mode;
  logic         prev_hold;
  logic [31:0]  prev_dt;
  logic [167:0] mem_pipe [RD_LAT];
  logic [1:0]   r_sel_v;
  logic [15:0]  r_addr_v;
  int           r_len_v, wait_n;

  function automatic int wpe(input logic [1:0] sel);
    case (sel)
      2'd1: return 3;
      2'd2: return 1;
      2'd3: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [191:0] mask_of(input logic [1:0] sel);
    int w;
    case (sel)
      2'd1: w = 72;
      2'd2: w = 32;
      2'd3: w = 168;
      default: w = 0;
    endcase
    return (192'd1 << w) - 192'd1;
  endfunction

  // Memory contents: each 32-bit lane tagged with address, lane index and select.
  function automatic logic [167:0] mem_pattern(input logic [1:0] sel, input logic [15:0] a);
    logic [191:0] v;
    for (int k = 0; k < 6; k++) v[32*k +: 32] = {a, 4'(k), 2'b00, sel, 8'hC3};
    return v[167:0];
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  always @(posedge clk) begin
    mem_pipe[0] <= mem_pattern(mem_sel_o, mem_addr_o);
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_r_dt = mem_pipe[RD_LAT-1];

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes or hands off a word.
  initial begin
    wr_t e;
    logic [31:0] d;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (mem_we_o) begin
          chk("we_expected", exp_wr.size() > 0, 1'b1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            chk("we_addr", mem_addr_o, e.addr);
            chk("we_sel", mem_sel_o, e.sel);
            chk("we_data", mem_w_dt_o, e.data);
          end
          last_evt_cyc = cyc;
          we_cyc.push_back(cyc);
        end
        if (prev_hold && m_valid_o) chk("m_dt_hold", m_dt_o, prev_dt);
        if (m_valid_o && m_ready) begin
          chk("rd_expected", exp_rd.size() > 0, 1'b1);
          if (exp_rd.size() > 0) begin
            d = exp_rd.pop_front();
            chk("rd_data", m_dt_o, d);
          end
          last_evt_cyc = cyc;
        end
        prev_hold = m_valid_o && !m_ready;
        prev_dt   = m_dt_o;
        if (done_o) begin
          done_cnt++;
          chk("done_after_last", cyc - last_evt_cyc, 1);
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic start_job(input logic dir, input logic [1:0] sel, input logic [15:0] addr, input int len);
    cfg_dir   = dir;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_len   = LEN_W'(len);
    cfg_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    logic acc;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_dt    = w;
    s_valid = 1'b1;
    n       = 0;
    acc     = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    chk("s_accept", acc, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_count", done_cnt, exp_done);
  endtask

  task automatic wr_job(input logic [1:0] sel, input logic [15:0] addr, input int len,
                        input int gapmax, input bit rnd);
    int w;
    logic [191:0] v;
    wr_t e;
    w = wpe(sel);
    if (rnd) begin
      stim_words.delete();
      for (int i = 0; i < len * w; i++) stim_words.push_back($urandom);
    end
    for (int en = 0; en < len; en++) begin
      v = 192'd0;
      for (int k = 0; k < w; k++) v = v | (192'(stim_words[en*w+k]) << (32 * k));
      v      = v & mask_of(sel);
      e.addr = addr + 16'(en);
      e.sel  = sel;
      e.data = v[167:0];
      exp_wr.push_back(e);
    end
    exp_done++;
    start_job(1'b0, sel, addr, len);
    chk("wr_busy_rise", busy_o, 1'b1);
    chk("wr_err_clear", err_o, 1'b0);
    for (int i = 0; i < len * w; i++) send_word(stim_words[i], $urandom_range(0, gapmax));
    wait_done();
    chk("wr_queue_empty", exp_wr.size(), 0);
  endtask

  task automatic rd_job(input logic [1:0] sel, input logic [15:0] addr, input int len, input int mode);
    int w;
    logic [191:0] v;
    w        = wpe(sel);
    rdy_mode = mode;
    for (int en = 0; en < len; en++) begin
      v = {24'd0, mem_pattern(sel, addr + 16'(en))} & mask_of(sel);
      for (int k = 0; k < w; k++) exp_rd.push_back(v[32*k +: 32]);
    end
    exp_done++;
    start_job(1'b1, sel, addr, len);
    chk("rd_busy_rise", busy_o, 1'b1);
    wait_done();
    chk("rd_queue_empty", exp_rd.size(), 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done_cnt = 0; exp_done = 0;
    last_evt_cyc = 0; last_done_cyc = 0; start_cyc = 0; rdy_mode = 0;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_sel = 2'd0;
    cfg_addr = 16'd0; cfg_len = '0; abort = 1'b0; s_dt = 32'd0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy_o, done_o, err_o, s_ready_o, m_valid_o, mem_we_o, mem_sel_o, mem_addr_o, m_dt_o}, 0);
    chk("reset_wdt", mem_w_dt_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DMEM write, back-to-back words, latency and throughput
    we_cyc.delete();
    stim_words = {32'h0000_000A, 32'h0000_000B};
    wr_job(2'd2, 16'h0010, 2, 0, 1'b0);
    chk("wr_strobe_count", we_cyc.size(), 2);
    if (we_cyc.size() == 2) begin
      chk("start_to_we", we_cyc[0] - start_cyc, 2);
      chk("we_spacing", we_cyc[1] - we_cyc[0], 2);
    end

    // PMEM write with valid gaps: upper bits of word 2 dropped
    stim_words = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    wr_job(2'd1, 16'h0005, 1, 3, 1'b0);

    // WMEM read, ready toggling
    rd_job(2'd3, 16'h0040, 2, 1);

    // Invalid starts
    start_job(1'b0, 2'd2, 16'h0020, 0);
    chk("err_len0", err_o, 1'b1);
    chk("busy_len0", busy_o, 1'b0);
    start_job(1'b0, 2'd0, 16'h0020, 1);
    chk("err_sel0", err_o, 1'b1);
    chk("busy_sel0", busy_o, 1'b0);
    wr_job(2'd2, 16'h0020, 1, 1, 1'b1);

    // Abort during WMEM fill after four words
    start_job(1'b0, 2'd3, 16'h0200, 1);
    for (int i = 0; i < 4; i++) send_word($urandom, 0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle", busy_o, 1'b0);
    chk("abort_sready", s_ready_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, exp_done);
    chk("abort_err", err_o, 1'b0);
    wr_job(2'd3, 16'h0200, 1, 1, 1'b1);

    // Address wrap
    wr_job(2'd2, 16'hFFFF, 2, 0, 1'b1);

    // Read throughput with ready held high
    rd_job(2'd2, 16'h0100, 3, 0);
    chk("rd_throughput", last_done_cyc - start_cyc, 3 * (1 + RD_LAT + 1) + 1);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      r_sel_v  = 2'($urandom_range(1, 3));
      r_len_v  = $urandom_range(1, 3);
      r_addr_v = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if ($urandom_range(0, 1) == 1) wr_job(r_sel_v, r_addr_v, r_len_v, 2, 1'b1);
      else rd_job(r_sel_v, r_addr_v, r_len_v, $urandom_range(1, 2));
    end

    // Reset while draining a read
    rdy_mode = 3;
    start_job(1'b1, 2'd3, 16'h0300, 2);
    wait_n = 0;
    while (!m_valid_o && wait_n < 100) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    chk("drain_reached", m_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {busy_o, done_o, err_o, s_ready_o, m_valid_o, mem_we_o, mem_sel_o, mem_addr_o, m_dt_o}, 0);
    chk("rst_wdt", mem_w_dt_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    wr_job(2'd1, 16'h0400, 1, 1, 1'b1);

    chk("final_wr_empty", exp_wr.size(), 0);
    chk("final_rd_empty", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
